// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    // Bits needed to count 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/seq_divider_8_if.sv
// Start/done handshake and operand/result bundle for seq_divider_8.
interface seq_divider_8_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, try to subtract.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quo_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // partial_rem < divisor holds between steps, so WIDTH+1 bits are enough for the sign.
    always_comb begin
        shifted  = {partial_rem, next_bit};
        trial    = shifted - {1'b0, divisor};
        quo_bit  = ~trial[WIDTH];
        rem_next = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider_8.sv
// Sequential restoring divider, one iteration per clock, latency WIDTH+1 edges.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider_8
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    seq_divider_8_if.slave bus
);
    localparam int unsigned CNT_W = clog2(WIDTH);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] rem_next;
    logic             quo_bit;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partial_rem(rem_q),
        .next_bit   (quo_q[WIDTH-1]),
        .divisor    (dsr_q),
        .rem_next   (rem_next),
        .quo_bit    (quo_bit)
    );

`ifdef DIV_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;

    always_comb begin
        dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dsr_mag = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    end

    // Zero divisor leaves |dividend| in rem_q, so restoring its sign gives the dividend back.
    always_comb begin
        res_quo = quo_q;
        res_rem = rem_q;
        if (dsr_q == '0) begin
            res_quo = '1;
        end else if (neg_quo_q) begin
            res_quo = -quo_q;
        end
        if (neg_rem_q) begin
            res_rem = -rem_q;
        end
    end
`else
    always_comb begin
        dvd_mag = bus.dividend;
        dsr_mag = bus.divisor;
        res_quo = quo_q;
        res_rem = rem_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        rem_q   <= '0;
                        quo_q   <= dvd_mag;
                        dsr_q   <= dsr_mag;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef DIV_SIGNED_EN
                        neg_quo_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_rem_q <= bus.dividend[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    // quo_q doubles as the dividend shifter: MSB feeds the step, LSB takes the bit.
                    rem_q <= rem_next;
                    quo_q <= {quo_q[WIDTH-2:0], quo_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    quotient_q  <= res_quo;
                    remainder_q <= res_rem;
                    dbz_q       <= (dsr_q == '0);
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_8.sv
// Scoreboard bench for seq_divider_8: driver pushes model results, monitor pops on done.
module tb_seq_divider_8;
    localparam int W = 8;
    localparam int LAT = W + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           edge_n;
    } exp_t;

    logic clk;
    logic rst;
    int   edges;
    int   checks;
    int   errors;
    int   busy_run;
    exp_t exp_q[$];
    exp_t hold_exp;

    seq_divider_8_if #(.WIDTH(W)) bus ();

    seq_divider_8 #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero in signed mode.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
`ifdef DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        if (sb == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = W'(sa / sb);
            e.r   = W'(sa % sb);
            e.dbz = 1'b0;
        end
        e.edge_n = 0;
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(a, b);
        e.edge_n = edges + LAT;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        push_exp(a, b);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial busy_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("quotient", 32'(bus.quotient), 32'(e.q));
                check("remainder", 32'(bus.remainder), 32'(e.r));
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                check("latency", 32'(edges), 32'(e.edge_n));
                check("busy_cycles", 32'(busy_run), 32'(LAT));
            end
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run = busy_run + 1;
            if (exp_q.size() > 0 && edges > exp_q[0].edge_n) begin
                check("missing_done", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        do_op(8'd200, 8'd7);
        do_op(8'd5, 8'd0);
        do_op(8'd3, 8'd10);

        // A start pulse mid-operation must be ignored.
        do_op(8'd255, 8'd1);
        hold_exp = model(8'd255, 8'd1);
        repeat (2) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_quotient", 32'(bus.quotient), 32'(hold_exp.q));
        check("hold_remainder", 32'(bus.remainder), 32'(hold_exp.r));

        // Abort with reset around iteration 4: no done for this one.
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_done", 32'(bus.done), 32'd0);
        do_op(8'd100, 8'd9);

        // start held high: back-to-back operations WIDTH+2 cycles apart.
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        @(posedge clk);
        #1;
        push_exp(8'd50, 8'd5);
        @(negedge clk);
        bus.dividend = 8'd51;
        repeat (LAT + 1) @(posedge clk);
        #1;
        push_exp(8'd51, 8'd5);
        @(negedge clk);
        bus.start = 1'b0;

`ifdef DIV_SIGNED_EN
        do_op(8'h9C, 8'd7);
        do_op(8'h80, 8'hFF);
        do_op(8'd100, 8'hF9);
`endif

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_op(a, b);
        end

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider_8.md
Name: seq_divider_8

Overview:
- Sequential restoring divider: the inverse operation to the team's 8x8 combinational array multiplier.
- Takes an 8-bit dividend and an 8-bit divisor through a start/done handshake and returns quotient and remainder after a fixed latency.
- Sits beside the multiplier in the arithmetic datapath; one iteration per clock keeps area small.

Parameters:
- WIDTH, 8, operand and result width in bits (must be ≥2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  numerator, captured when start is accepted
- divisor  in  WIDTH  denominator, captured when start is accepted
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse when results are valid
- quotient  out  WIDTH  result; holds until the next done
- remainder  out  WIDTH  result; holds until the next done
- div_by_zero  out  1  set with done when the captured divisor was 0; holds with results

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE; busy, done, div_by_zero, quotient and remainder all 0; iteration counter 0.
- State machine:
  - IDLE: start=1 captures the operands, clears the working registers, sets busy, then goes to RUN.
  - RUN: performs WIDTH iterations, one per clock, counter 0..WIDTH-1.
  - FINISH: registers the results, pulses done, clears busy, then returns to IDLE.
- Iteration (restoring):
  - Shift {partial_rem, work_quo} left by 1.
  - Form trial = partial_rem - divisor as a (WIDTH+1)-bit value.
  - If trial is non-negative: partial_rem = trial and the new quotient LSB = 1; else keep partial_rem and the LSB = 0.
- Latency: start sampled at edge T. Iterations occur at edges T+1..T+WIDTH. done is high for exactly the cycle after edge T+WIDTH+1 (latency WIDTH+1 edges). This latency is identical for every operand value.
- Divide by zero: needs no special datapath. The algorithm naturally yields quotient = all ones and remainder = dividend. div_by_zero = (captured divisor == 0), registered with done.
- start while busy, or in the FINISH state: ignored; no queueing. The operand inputs may change freely while busy.
- start held high continuously: a new operation is accepted in the IDLE cycle after done, giving back-to-back throughput of one result per WIDTH+2 cycles.
- rst asserted mid-operation: immediate abort to the reset values. No done is produced for the aborted operation.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are divided unsigned.
  - At FINISH the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign (truncation toward zero).
  - -2^(WIDTH-1) / -1 gives quotient 0x80 (wrap) and remainder 0.
  - Divide by zero forces quotient all ones and remainder = dividend.
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesised.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, RUN, FINISH};
  - DIV_WIDTH_DEFAULT = 8;
  - counter width function clog2(WIDTH).
- Sub-module div_step: combinational single restoring iteration. Inputs are partial_rem, the next dividend bit and divisor; outputs are the new partial_rem and the quotient bit. Instantiated once inside seq_divider_8.

Test Plan:
- 200/7 → quotient 28, remainder 4, div_by_zero 0; done exactly 9 edges after start is sampled; busy high for the 9 preceding cycles.
- 5/0 → quotient 0xFF, remainder 5, div_by_zero 1, same 9-edge latency; then 3/10 → quotient 0, remainder 3, div_by_zero cleared.
- 255/1 → quotient 255, remainder 0. Pulse start again at cycle 4 with 9/3: it is ignored, and the results remain 255/0.
- Start 100/9, assert rst for 1 cycle at iteration 4 → all outputs 0, no done pulse. Then 100/9 → quotient 11, remainder 1.
- start held high with the operand sequence 50/5, 51/5 → done pulses 10 cycles apart, with results 10/0 then 10/1.
- DIV_SIGNED_EN: -100/7 → quotient 0xF2 (-14), remainder 0xFE (-2); -128/-1 → quotient 0x80, remainder 0; 100/-7 → quotient 0xF2, remainder 0x02.
